// File: rtl/spinner_quad_encoder.sv
// Spinner quadrature encoder: turns mouse X motion and d-pad holds
// into a fixed-rate {A,B} quadrature stream for the Arkanoid core.
module spinner_quad_encoder #(
  parameter int CLK_HZ      = 48000000,
  parameter int STEP_HZ     = 4000,
  parameter int DPAD_CYCLES = 384000,
  parameter int DPAD_SLOW   = 4,
  parameter int DPAD_FAST   = 9,
  parameter int ACC_W       = 12
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_x,
  input  logic       dpad_left,
  input  logic       dpad_right,
  input  logic       dpad_fast,
  output logic [1:0] enc_out,
  output logic       busy
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int SW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DPAD_CYCLES > 1) ?
                       $clog2(DPAD_CYCLES) : 1;
  localparam int XW  = ACC_W + 1;

  localparam logic signed [XW-1:0] ACC_MAX =
    XW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [XW-1:0] ACC_MIN =
    XW'(-(2 ** (ACC_W - 1)));

  localparam logic [SW-1:0] STEP_LAST = SW'(DIV - 1);
  localparam logic [DW-1:0] DPAD_LAST =
    DW'(DPAD_CYCLES - 1);

  logic [SW-1:0]           step_cnt;
  logic                    tick;
  logic [DW-1:0]           dpad_cnt;
  logic                    dpad_any;
  logic                    load;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mag;
  logic signed [ACC_W-1:0] load_val;
  logic signed [ACC_W-1:0] dir_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [XW-1:0]    base_ext;
  logic signed [XW-1:0]    mx_ext;
  logic signed [XW-1:0]    sum;
  logic signed [1:0]       stepdir;
  logic [1:0]              enc_nxt;

  assign tick     = (step_cnt == STEP_LAST);
  assign dpad_any = dpad_left | dpad_right;
  assign load     = dpad_any && (dpad_cnt == DPAD_LAST);

  // Step direction follows the sign of pending motion on each tick
  always_comb begin
    stepdir = 2'sb00;
    if (tick && (acc != '0)) begin
      stepdir = acc[ACC_W-1] ? 2'sb11 : 2'sb01;
    end
  end

  // Base value, mouse addition and saturation of the accumulator
  always_comb begin
    mag      = dpad_fast ? ACC_W'(DPAD_FAST)
                         : ACC_W'(DPAD_SLOW);
    load_val = dpad_right ? mag : -mag;
    dir_ext  = ACC_W'(stepdir);
    base     = load ? load_val : (acc - dir_ext);
    base_ext = XW'(base);
    mx_ext   = XW'($signed(mouse_x));
    sum      = base_ext + mx_ext;
    acc_nxt  = base;
    if (mouse_strobe) begin
      unique case (1'b1)
        (sum > ACC_MAX): acc_nxt = ACC_MAX[ACC_W-1:0];
        (sum < ACC_MIN): acc_nxt = ACC_MIN[ACC_W-1:0];
        default:         acc_nxt = sum[ACC_W-1:0];
      endcase
    end
  end

  // Next quadrature phase: one Gray step per tick
  always_comb begin
    enc_nxt = enc_out;
    unique case (1'b1)
      (stepdir == 2'sb01): begin
        case (enc_out)
          2'b00:   enc_nxt = 2'b10;
          2'b10:   enc_nxt = 2'b11;
          2'b11:   enc_nxt = 2'b01;
          default: enc_nxt = 2'b00;
        endcase
      end
      (stepdir == 2'sb11): begin
        case (enc_out)
          2'b00:   enc_nxt = 2'b01;
          2'b01:   enc_nxt = 2'b11;
          2'b11:   enc_nxt = 2'b10;
          default: enc_nxt = 2'b00;
        endcase
      end
      default: enc_nxt = enc_out;
    endcase
  end

  // Free-running step divider
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
    end else if (tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // D-pad reload period counter, cleared when released
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dpad_cnt <= '0;
    end else if (!dpad_any || load) begin
      dpad_cnt <= '0;
    end else begin
      dpad_cnt <= dpad_cnt + 1'b1;
    end
  end

  // Accumulator, busy flag and phase register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      busy    <= 1'b0;
      enc_out <= 2'b00;
    end else begin
      acc     <= acc_nxt;
      busy    <= (acc_nxt != '0);
      enc_out <= enc_nxt;
    end
  end

endmodule

// File: tb/tb_spinner_quad_encoder.sv
// Bench for spinner_quad_encoder: directed steps with a
// phase scoreboard fed by a reference accumulator model.
module tb_spinner_quad_encoder;

  localparam int DIV  = 10;
  localparam int DPC  = 40;
  localparam int AMAX = 2047;
  localparam int AMIN = -2048;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       mouse_strobe = 1'b0;
  logic [8:0] mouse_x = 9'd0;
  logic       dpad_left = 1'b0;
  logic       dpad_right = 1'b0;
  logic       dpad_fast = 1'b0;
  logic [1:0] enc_out;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int         m = 0;
  int         tcnt = 0;
  int         dcnt = 0;
  logic [1:0] ph = 2'b00;
  logic [1:0] q[$];
  logic [1:0] prev = 2'b00;
  logic [1:0] exp_ph;

  spinner_quad_encoder #(
    .CLK_HZ(100),
    .STEP_HZ(10),
    .DPAD_CYCLES(DPC),
    .DPAD_SLOW(4),
    .DPAD_FAST(9),
    .ACC_W(12)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .mouse_strobe(mouse_strobe),
    .mouse_x(mouse_x),
    .dpad_left(dpad_left),
    .dpad_right(dpad_right),
    .dpad_fast(dpad_fast),
    .enc_out(enc_out),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ph_pos(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ph_neg(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive(input logic s, input int x,
                       input logic l, input logic r,
                       input logic f);
    int dir;
    int base;
    int v;
    logic ld;
    mouse_strobe = s;
    mouse_x      = 9'(x);
    dpad_left    = l;
    dpad_right   = r;
    dpad_fast    = f;
    dir = 0;
    if (tcnt == DIV - 1 && m != 0) dir = (m > 0) ? 1 : -1;
    ld = (l | r) && (dcnt == DPC - 1);
    if (ld) base = r ? (f ? 9 : 4) : (f ? -9 : -4);
    else    base = m - dir;
    v = s ? base + x : base;
    if (v > AMAX) v = AMAX;
    if (v < AMIN) v = AMIN;
    if (dir > 0) begin
      ph = ph_pos(ph);
      q.push_back(ph);
    end else if (dir < 0) begin
      ph = ph_neg(ph);
      q.push_back(ph);
    end
    @(posedge clk_sys);
    #1;
    m    = v;
    tcnt = (tcnt == DIV - 1) ? 0 : tcnt + 1;
    if (!(l | r) || ld) dcnt = 0;
    else dcnt = dcnt + 1;
    mouse_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic align(input int t);
    for (int i = 0; i < DIV && tcnt != t; i++) idle(1);
  endtask

  task automatic chk_acc(input string tag, input int exp);
    chk(tag, 32'(dut.acc), 32'(exp));
  endtask

  task automatic chk_q(input string tag);
    @(negedge clk_sys);
    #1;
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_enc", 32'(enc_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    chk_acc("rst_acc", 0);
    reset_n = 1'b1;
    m = 0;
    tcnt = 0;
    dcnt = 0;
    ph = 2'b00;
    q.delete();
  endtask

  // Scoreboard: every phase change must be the next queued phase
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev = enc_out;
    end else if (enc_out !== prev) begin
      chk("enc_onebit",
          32'($countones(enc_out ^ prev)), 32'd1);
      chk("enc_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_ph = q.pop_front();
        chk("enc_seq", 32'(enc_out), 32'(exp_ph));
      end
      prev = enc_out;
    end
  end

  initial begin
    do_reset();

    align(0);
    drive(1'b1, 100, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk_acc("t1_acc100", 100);
    chk("t1_busy", 32'(busy), 32'd1);
    do_reset();

    align(0);
    drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
    chk_acc("t2_acc3", 3);
    idle(3 * DIV);
    chk_q("t2_q");
    chk("t2_enc", 32'(enc_out), 32'h1);
    chk("t2_busy", 32'(busy), 32'd0);
    idle(DIV);
    chk("t2_hold", 32'(enc_out), 32'h1);

    do_reset();
    align(0);
    drive(1'b1, -5, 1'b0, 1'b0, 1'b0);
    chk_acc("t3_accm5", -5);
    idle(5 * DIV);
    chk_q("t3_q");
    chk("t3_enc", 32'(enc_out), 32'h1);
    chk_acc("t3_acc0", 0);
    chk("t3_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 127, 1'b0, 1'b0, 1'b0);
      chk("t4_nonneg", 32'(dut.acc[11]), 32'd0);
    end
    chk_acc("t4_sat", AMAX);
    drive(1'b1, -256, 1'b0, 1'b0, 1'b0);
    chk_acc("t4_sub", m);
    chk("t4_range", 32'(m >= 1790 && m <= 1791), 32'd1);
    idle((m + 1) * DIV);
    chk_q("t4_q");
    chk_acc("t4_drain", 0);
    chk("t4_enc", 32'(enc_out), 32'(ph));

    do_reset();
    align(0);
    drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
    align(DIV - 1);
    chk_acc("t5_acc5", 5);
    drive(1'b1, 2, 1'b0, 1'b0, 1'b0);
    chk_acc("t5_tick", 6);

    do_reset();
    repeat (DPC - 1) drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk_acc("t5_preload", 0);
    drive(1'b1, 2, 1'b0, 1'b1, 1'b1);
    chk_acc("t5_load", 11);

    do_reset();
    repeat (DPC - 1) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_acc("t6_noload", 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_acc("t6_right", 4);
    idle(1);
    repeat (DPC) drive(1'b0, 0, 1'b1, 1'b1, 1'b1);
    chk_acc("t6_both", 9);
    idle(1);
    repeat (DPC) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk_acc("t6_left", -4);
    idle(1);
    repeat (30) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_acc("t6_early", m);
    idle(1);
    repeat (DPC - 1) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_acc("t6_restart", m);
    chk("t6_notyet", 32'(dcnt), 32'(DPC - 1));
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_acc("t6_reload", 4);
    idle(1);
    chk_q("t6_q");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
